// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Purpose  : Hazard / forwarding controller for a 5-stage RISC-V pipeline.
//            Produces 2-bit operand forwarding selects (Memory beats
//            Writeback), load-use stalls, branch flushes, stalls for a
//            multi-cycle Execute op of MC_LAT cycles, data-memory wait-state
//            freezing, and a saturating count of cycles with StallF=1.
// Ports    : clock/reset (async, active-low)
//            Rs1D,Rs2D,Rs1E,Rs2E,RdE,RdM,RdW        register addresses
//            RegWriteM,RegWriteW,LoadE,PCSrcE,
//            MultiCycleE,MemReadyM                  pipeline status
//            StallF/D/E/M, FlushD/E/M/W             stage controls
//            ForwardAE/BE                           00 RF, 01 ResultW, 10 ALUResultM
//            mc_busy, stall_count                   status / performance
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LoadE,
    input  logic              PCSrcE,
    input  logic              MultiCycleE,
    input  logic              MemReadyM,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              FlushW,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int CW     = $clog2(MC_LAT) + 1;
    localparam int INIT_I = (MC_LAT > 1) ? (MC_LAT - 2) : 0;
    localparam logic [CW-1:0] CNT_INIT = INIT_I[CW-1:0];
    localparam logic MC_EN = (MC_LAT > 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MC_BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    logic mem_stall;
    logic mc_start;
    logic mc_stall;
    logic lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (RegWriteM && (RdM != '0) && (RdM == rs))
            return 2'b10;
        else if (RegWriteW && (RdW != '0) && (RdW == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        mem_stall = !MemReadyM;
        // The first cycle of an op already stalls, before the FSM has moved.
        mc_start  = (state == IDLE) && MultiCycleE && MC_EN;
        mc_stall  = mc_start || ((state == MC_BUSY) && (cnt != '0));
        lw_stall  = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    end

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        mc_busy   = 1'b0;
        if (reset) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            mc_busy   = (state == MC_BUSY);
            if (mem_stall) begin
                // Freeze everything up to Memory; bubble into Writeback.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (mc_stall) begin
                // A branch or load-use cannot act while Execute is held.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!mem_stall) begin
            case (state)
                IDLE: begin
                    if (mc_start) begin
                        state <= MC_BUSY;
                        cnt   <= CNT_INIT;
                    end
                end
                MC_BUSY: begin
                    if (cnt != '0)
                        cnt <= cnt - CW'(1);
                    else
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (StallF && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit_mc
// Purpose  : Self-checking bench for hazard_unit_mc. Two instances share the
//            stimulus: MC_LAT=4/CNT_W=32 and MC_LAT=1/CNT_W=3. A behavioural
//            model tracks "cycles the op still owns Execute" and the stall
//            count per instance and is compared every falling edge; directed
//            literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [4:0] RdE = '0, RdM = '0, RdW = '0;
    logic RegWriteM = 0, RegWriteW = 0, LoadE = 0, PCSrcE = 0;
    logic MultiCycleE = 0, MemReadyM = 1;

    logic sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, mb0;
    logic [1:0] fa0, fb0;
    logic [31:0] sc0;
    logic sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, mb1;
    logic [1:0] fa1, fb1;
    logic [2:0] sc1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .CNT_W(32)) dut0 (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .MemReadyM(MemReadyM),
        .StallF(sF0), .StallD(sD0), .StallE(sE0), .StallM(sM0),
        .FlushD(fD0), .FlushE(fE0), .FlushM(fM0), .FlushW(fW0),
        .ForwardAE(fa0), .ForwardBE(fb0), .mc_busy(mb0), .stall_count(sc0)
    );

    hazard_unit_mc #(.REG_AW(5), .MC_LAT(1), .CNT_W(3)) dut1 (
        .clock(clock), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
        .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .MemReadyM(MemReadyM),
        .StallF(sF1), .StallD(sD1), .StallE(sE1), .StallM(sM1),
        .FlushD(fD1), .FlushE(fE1), .FlushM(fM1), .FlushW(fW1),
        .ForwardAE(fa1), .ForwardBE(fb1), .mc_busy(mb1), .stall_count(sc1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     lat_v [2] = '{4, 1};
    longint cmax  [2] = '{64'h0000_0000_FFFF_FFFF, 64'd7};
    int     op_left [2] = '{0, 0};   // cycles the op still holds Execute
    int     op_nxt  [2] = '{0, 0};
    longint cnt_m   [2] = '{0, 0};
    longint cnt_nxt [2] = '{0, 0};

    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'd2;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'd1;
        return 2'd0;
    endfunction

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic [12:0] exp_v, act_v;
            logic [63:0] act_c;
            logic ms, lw, br, mcs, st_f;
            int eff;
            ms  = !MemReadyM;
            br  = PCSrcE;
            lw  = LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            eff = (op_left[i] == 0 && MultiCycleE) ? lat_v[i] : op_left[i];
            mcs = (eff > 1);
            if (!reset) begin
                exp_v = '0;
                st_f  = 1'b0;
            end else if (ms) begin
                // {StallF,D,E,M, FlushD,E,M,W, FwdA, FwdB, busy}
                exp_v = {4'b1111, 4'b0001, fwd_model(Rs1E), fwd_model(Rs2E), op_left[i] > 0};
                st_f  = 1'b1;
            end else begin
                st_f  = mcs | (lw & !br);
                exp_v = {st_f, st_f, mcs, 1'b0,
                         br & !mcs, (br | lw) & !mcs, mcs, 1'b0,
                         fwd_model(Rs1E), fwd_model(Rs2E), op_left[i] > 0};
            end
            op_nxt[i]  = ms ? op_left[i] : (mcs ? eff - 1 : 0);
            cnt_nxt[i] = (st_f && cnt_m[i] < cmax[i]) ? cnt_m[i] + 1 : cnt_m[i];
            if (i == 0) begin
                act_v = {sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, fa0, fb0, mb0};
                act_c = 64'(sc0);
            end else begin
                act_v = {sF1, sD1, sE1, sM1, fD1, fE1, fM1, fW1, fa1, fb1, mb1};
                act_c = 64'(sc1);
            end
            check($sformatf("cmp%0d_ctl", i), 64'(act_v), 64'(exp_v));
            check($sformatf("cmp%0d_count", i), act_c, 64'(cnt_m[i]));
        end
    end

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                op_left[i] = 0;
                cnt_m[i]   = 0;
            end else begin
                op_left[i] = op_nxt[i];
                cnt_m[i]   = cnt_nxt[i];
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; LoadE = 0; PCSrcE = 0;
        MultiCycleE = 0; MemReadyM = 1;
    endtask

    initial begin
        logic [31:0] base;
        clear_inputs();
        sample();
        check("reset_ctl", 64'({sF0, sD0, sE0, sM0, fD0, fE0, fM0, fW0, mb0}), 0);
        check("reset_count", 64'(sc0), 0);
        #2 reset = 1'b1;

        // Forwarding priority
        step(); Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
        sample(); check("fwdA_mem", 64'(fa0), 2);
        step(); RegWriteM = 0;
        sample(); check("fwdA_wb", 64'(fa0), 1);
        step(); Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        sample(); check("fwdA_x0", 64'(fa0), 0);
        step(); Rs1E = 0; Rs2E = 5; RdM = 5; RdW = 5;
        sample(); check("fwdB_mem", 64'(fb0), 2);
        step(); RegWriteM = 0;
        sample(); check("fwdB_wb", 64'(fb0), 1);
        step(); Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        sample(); check("fwdB_x0", 64'(fb0), 0);

        // Load-use
        step(); clear_inputs(); base = sc0; LoadE = 1; RdE = 7; Rs2D = 7;
        sample(); check("lw_stall", 64'({sF0, sD0, sE0, fE0}), 64'b1101);
        step(); clear_inputs();
        sample(); check("lw_one_cycle", 64'(sF0), 0);
        check("lw_count", 64'(sc0), 64'(base + 1));
        step(); LoadE = 1; RdE = 0; Rs2D = 0;
        sample(); check("lw_x0", 64'({sF0, sD0, fE0}), 0);

        // Multi-cycle op, unhindered
        step(); clear_inputs(); base = sc0; MultiCycleE = 1;
        sample();
        check("mc_c0", 64'({sF0, sD0, sE0, fM0, mb0}), 64'b11110);
        check("mc_lat1_nostall", 64'({sF1, sE1, mb1}), 0);
        step(); MultiCycleE = 0;
        for (int c = 1; c <= 3; c++) begin
            sample();
            check($sformatf("mc_c%0d", c), 64'({sF0, sD0, sE0, fM0, mb0}),
                  (c < 3) ? 64'b11111 : 64'b00001);
            step();
        end
        sample();
        check("mc_done", 64'(mb0), 0);
        check("mc_count", 64'(sc0), 64'(base + 3));

        // Multi-cycle op with a 2-cycle memory wait while cnt=1
        step(); base = sc0; MultiCycleE = 1;
        sample(); step(); MultiCycleE = 0;
        sample(); step(); MemReadyM = 0;
        sample(); check("mw_c2", 64'({sF0, sD0, sE0, sM0, fM0, fW0}), 64'b111101);
        step();
        sample(); check("mw_c3", 64'({sF0, sM0, fM0, fW0, mb0}), 64'b11011);
        step(); MemReadyM = 1;
        sample(); check("mw_c4", 64'({sF0, fM0, mb0}), 64'b111);
        step();
        sample(); check("mw_exit", 64'({sF0, mb0}), 64'b01);
        step();
        sample(); check("mw_done", 64'(mb0), 0);
        check("mw_count", 64'(sc0), 64'(base + 5));

        // Branch interactions
        step(); PCSrcE = 1; LoadE = 1; RdE = 7; Rs2D = 7;
        sample(); check("br_over_lw", 64'({fD0, fE0, sF0, sD0}), 64'b1100);
        step(); MemReadyM = 0;
        sample(); check("br_memwait", 64'({fD0, fE0, fW0}), 64'b001);
        step(); clear_inputs();

        // Saturation of the 3-bit counter
        base = sc0; MemReadyM = 0;
        repeat (9) step();
        step(); MemReadyM = 1;
        sample();
        check("sat_count3", 64'(sc1), 7);
        check("sat_count32", 64'(sc0), 64'(base + 10));
        step();
        sample(); check("sat_hold", 64'(sc1), 7);

        // Randomized traffic
        repeat (2000) begin
            step();
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            LoadE = ($urandom_range(0, 2) == 0);
            PCSrcE = ($urandom_range(0, 7) == 0);
            MultiCycleE = ($urandom_range(0, 7) == 0);
            MemReadyM = ($urandom_range(0, 5) != 0);
        end

        // Asynchronous reset while an op is in MC_BUSY
        step(); clear_inputs(); MultiCycleE = 1;
        step(); MultiCycleE = 0;
        check("ar_busy_before", 64'(mb0), 1);
        #1 reset = 1'b0;
        #1;
        check("ar_ctl", 64'({sF0, sD0, sE0, fM0, mb0}), 0);
        check("ar_count", 64'(sc0), 0);
        sample();
        #1 reset = 1'b1;
        step();
        sample(); check("ar_after", 64'({sF0, mb0}), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
